// File: rtl/mem_access_unit_if.sv
// Processor request/response and memory-port signals of mem_access_unit.
// slave is the unit's view; master is the processor/memory side driving it.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wdata, mem_ren, mem_wen
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wdata, mem_ren, mem_wen
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit over a 32-bit word memory port; sub-word stores use read-modify-write.
// Optional macro MEM_ACC_ALIGN_CHK_EN rejects misaligned halfword/word accesses.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 512
) (
    input logic             clk,
    input logic             reset,
    mem_access_unit_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] MAX_ADDR = AW'(MEM_BYTES - 4);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_ren_q, mem_ren_d;
    logic          mem_wen_q, mem_wen_d;

    function automatic logic is_illegal(input logic [1:0] sz, input logic [AW-1:0] a);
        logic bad;
        bad = (sz == 2'b11) || (a > MAX_ADDR);
`ifdef MEM_ACC_ALIGN_CHK_EN
        if ((sz == 2'b01) && a[0]) bad = 1'b1;
        if ((sz == 2'b10) && (a[1:0] != 2'b00)) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [DW-1:0] load_result(input logic [1:0] sz, input logic sx,
                                                  input logic [DW-1:0] d);
        logic [DW-1:0] r;
        case (sz)
            2'b00:   r = {{24{sx & d[7]}}, d[7:0]};
            2'b01:   r = {{16{sx & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Merge new sub-word store data into the word just read back.
    function automatic logic [DW-1:0] merge_store(input logic [1:0] sz, input logic [DW-1:0] old,
                                                  input logic [DW-1:0] wd);
        logic [DW-1:0] r;
        if (sz == 2'b00) r = {old[31:8], wd[7:0]};
        else             r = {old[31:16], wd[15:0]};
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sext_d  = bus.sign_ext;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (is_illegal(bus.size, bus.addr)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (bus.we && (bus.size == 2'b10)) begin
                        state_d     = WR_ISSUE;
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = bus.addr;
                        mem_wdata_d = bus.wdata;
                    end else begin
                        state_d    = RD_ISSUE;
                        mem_ren_d  = 1'b1;
                        mem_addr_d = bus.addr;
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (we_q) begin
                    state_d     = WR_ISSUE;
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = merge_store(size_q, bus.mem_rdata, wdata_q);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = load_result(size_q, sext_q, bus.mem_rdata);
                end
            end
            WR_ISSUE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_ren   = mem_ren_q;
    assign bus.mem_wen   = mem_wen_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: byte-array reference model plus per-cycle output compare.
module tb_mem_access_unit;
    localparam int unsigned MEM_BYTES = 512;
    localparam int LIT_RD  = 1;
    localparam int LIT_LAT = 2;
    localparam int LIT_WD  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // Attached memory: word port, read data one cycle after ren.
    logic [7:0] mem_env [MEM_BYTES];
    int env_a;
    assign env_a = int'(bus.mem_addr);
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem_env[i] <= init_byte(i);
            bus.mem_rdata <= 32'h0;
        end else begin
            if (bus.mem_ren) begin
                if (bus.mem_addr <= 32'(MEM_BYTES - 4))
                    bus.mem_rdata <= {mem_env[env_a+3], mem_env[env_a+2], mem_env[env_a+1], mem_env[env_a]};
                else
                    bus.mem_rdata <= 32'hBAD0BAD0;
            end
            if (bus.mem_wen && (bus.mem_addr <= 32'(MEM_BYTES - 4))) begin
                mem_env[env_a]   <= bus.mem_wdata[7:0];
                mem_env[env_a+1] <= bus.mem_wdata[15:8];
                mem_env[env_a+2] <= bus.mem_wdata[23:16];
                mem_env[env_a+3] <= bus.mem_wdata[31:24];
            end
        end
    end

    // Reference model state (owned by the compare process).
    logic [7:0] ref_mem [MEM_BYTES];
    int n_chk = 0;
    int n_err = 0;

    // Expectation handed from driver to compare process.
    int          pend_seq = 0;
    logic        pend_err, pend_ren, pend_wen, pend_commit;
    logic [31:0] pend_rdata, pend_addr, pend_wdata, pend_newword;
    int          pend_lat;
    int          pend_lit;
    logic [31:0] lit_rdata, lit_wdata;
    logic        lit_err;
    int          lit_lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Compare process: checks DUT outputs every cycle, just after the active edge.
    initial begin : compare
        int seen_seq, left, cyc, done_cyc, ren_cnt, wen_cnt, ai;
        bit active;
        logic [31:0] seen_wdata;
        seen_seq = 0; active = 0; left = 0; cyc = 0; done_cyc = -1;
        ren_cnt = 0; wen_cnt = 0; seen_wdata = 0; ai = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                chk("rst_busy",      32'(bus.busy),    32'h0);
                chk("rst_done",      32'(bus.done),    32'h0);
                chk("rst_err",       32'(bus.err),     32'h0);
                chk("rst_rdata",     bus.rdata,        32'h0);
                chk("rst_mem_addr",  bus.mem_addr,     32'h0);
                chk("rst_mem_wdata", bus.mem_wdata,    32'h0);
                chk("rst_mem_ren",   32'(bus.mem_ren), 32'h0);
                chk("rst_mem_wen",   32'(bus.mem_wen), 32'h0);
                for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = init_byte(i);
                active   = 0;
                seen_seq = pend_seq;
            end else begin
                chk("ren_wen_excl", 32'(bus.mem_ren & bus.mem_wen), 32'h0);
                if (pend_seq != seen_seq) begin
                    seen_seq = pend_seq;
                    active = 1; left = pend_lat; cyc = 0; done_cyc = -1;
                    ren_cnt = 0; wen_cnt = 0; seen_wdata = 32'h0;
                end
                if (active) begin
                    left--; cyc++;
                    if (bus.done && done_cyc < 0) done_cyc = cyc;
                    if (bus.mem_ren) begin
                        ren_cnt++;
                        chk("ren_addr", bus.mem_addr, pend_addr);
                        chk("ren_before_wen", 32'(wen_cnt), 32'h0);
                    end
                    if (bus.mem_wen) begin
                        wen_cnt++;
                        seen_wdata = bus.mem_wdata;
                        chk("wen_addr", bus.mem_addr, pend_addr);
                        chk("wen_data", bus.mem_wdata, pend_wdata);
                        chk("wen_after_ren", 32'(ren_cnt), 32'(pend_ren));
                    end
                    chk("busy_active", 32'(bus.busy), 32'h1);
                    if (left > 0) begin
                        chk("early_done", 32'(bus.done), 32'h0);
                    end else begin
                        chk("done",      32'(bus.done), 32'h1);
                        chk("err",       32'(bus.err),  32'(pend_err));
                        chk("rdata",     bus.rdata,     pend_rdata);
                        chk("ren_count", 32'(ren_cnt),  32'(pend_ren));
                        chk("wen_count", 32'(wen_cnt),  32'(pend_wen));
                        if ((pend_lit & LIT_RD) != 0) begin
                            chk("lit_rdata", bus.rdata, lit_rdata);
                            chk("lit_err", 32'(bus.err), 32'(lit_err));
                        end
                        if ((pend_lit & LIT_LAT) != 0) chk("lit_latency", 32'(done_cyc), 32'(lit_lat));
                        if ((pend_lit & LIT_WD) != 0)  chk("lit_mem_wdata", seen_wdata, lit_wdata);
                        if (pend_commit) begin
                            ai = int'(pend_addr);
                            ref_mem[ai]   = pend_newword[7:0];
                            ref_mem[ai+1] = pend_newword[15:8];
                            ref_mem[ai+2] = pend_newword[23:16];
                            ref_mem[ai+3] = pend_newword[31:24];
                        end
                        active = 0;
                    end
                end else begin
                    chk("idle_done", 32'(bus.done),    32'h0);
                    chk("idle_busy", 32'(bus.busy),    32'h0);
                    chk("idle_ren",  32'(bus.mem_ren), 32'h0);
                    chk("idle_wen",  32'(bus.mem_wen), 32'h0);
                end
            end
        end
    end

    // Compute the expected outcome of one request from the byte-level model, then drive it.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input int lit, input logic [31:0] lr, input logic le,
                         input int ll, input logic [31:0] lw, input bit abort);
        logic       legal;
        logic [7:0] b [4];
        logic [7:0] nb [4];
        int         ai;
        @(negedge clk);
        legal = (sz != 2'b11) && (a <= 32'(MEM_BYTES - 4));
`ifdef MEM_ACC_ALIGN_CHK_EN
        if (sz == 2'b01 && (a % 2) != 0) legal = 1'b0;
        if (sz == 2'b10 && (a % 4) != 0) legal = 1'b0;
`endif
        pend_err = !legal; pend_rdata = 32'h0; pend_ren = 1'b0; pend_wen = 1'b0;
        pend_commit = 1'b0; pend_wdata = 32'h0; pend_newword = 32'h0; pend_addr = a; pend_lat = 1;
        if (legal) begin
            ai = int'(a);
            for (int k = 0; k < 4; k++) begin b[k] = ref_mem[ai+k]; nb[k] = b[k]; end
            if (!w) begin
                pend_lat = 3; pend_ren = 1'b1;
                if (sz == 2'b00) begin
                    pend_rdata = 32'(b[0]);
                    if (sx && b[0][7]) pend_rdata = pend_rdata | 32'hFFFFFF00;
                end else if (sz == 2'b01) begin
                    pend_rdata = 32'({b[1], b[0]});
                    if (sx && b[1][7]) pend_rdata = pend_rdata | 32'hFFFF0000;
                end else begin
                    pend_rdata = {b[3], b[2], b[1], b[0]};
                end
            end else begin
                nb[0] = wd[7:0];
                if (sz != 2'b00) nb[1] = wd[15:8];
                if (sz == 2'b10) begin nb[2] = wd[23:16]; nb[3] = wd[31:24]; end
                pend_newword = {nb[3], nb[2], nb[1], nb[0]};
                pend_wdata   = pend_newword;
                pend_commit  = 1'b1;
                pend_wen     = 1'b1;
                pend_ren     = (sz != 2'b10);
                pend_lat     = (sz == 2'b10) ? 2 : 4;
            end
        end
        pend_lit = lit; lit_rdata = lr; lit_err = le; lit_lat = ll; lit_wdata = lw;
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        pend_seq++;
        if (abort) begin
            @(negedge clk);
            bus.req = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end else begin
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (bus.done) break;
                bus.req = 1'($urandom); bus.we = 1'($urandom); bus.size = 2'($urandom);
                bus.sign_ext = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
            end
            bus.req = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run still going at %0t, required to have ended", $time);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] a;
        logic [1:0]  sz;
        reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, LIT_LAT, 0, 0, 2, 0, 0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, LIT_RD | LIT_LAT, 32'hDEADBEEF, 0, 3, 0, 0);
        issue(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 0, 0, 0, 0);
        issue(1, 2'b00, 0, 32'h20, 32'h000000AA, LIT_LAT | LIT_WD, 0, 0, 4, 32'h112233AA, 0);
        issue(0, 2'b10, 0, 32'h20, 32'h0, LIT_RD, 32'h112233AA, 0, 0, 0, 0);
        issue(1, 2'b00, 0, 32'h30, 32'h12345680, 0, 0, 0, 0, 0, 0);
        issue(0, 2'b00, 1, 32'h30, 32'h0, LIT_RD | LIT_LAT, 32'hFFFFFF80, 0, 3, 0, 0);
        issue(0, 2'b00, 0, 32'h30, 32'h0, LIT_RD, 32'h00000080, 0, 0, 0, 0);
        issue(0, 2'b11, 0, 32'h0, 32'h0, LIT_RD | LIT_LAT, 32'h0, 1, 1, 0, 0);
        issue(0, 2'b10, 0, 32'h1FE, 32'h0, LIT_RD | LIT_LAT, 32'h0, 1, 1, 0, 0);
`ifdef MEM_ACC_ALIGN_CHK_EN
        issue(0, 2'b01, 0, 32'h21, 32'h0, LIT_RD | LIT_LAT, 32'h0, 1, 1, 0, 0);
`else
        issue(0, 2'b01, 0, 32'h21, 32'h0, LIT_RD | LIT_LAT, 32'h00002233, 0, 3, 0, 0);
`endif
        issue(1, 2'b00, 0, 32'h40, 32'h00000055, 0, 0, 0, 0, 0, 1);
        repeat (4) @(negedge clk);
        issue(0, 2'b00, 0, 32'h40, 32'h0, LIT_RD, 32'h00000043, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(MEM_BYTES - 6) + 32'($urandom_range(0, 8));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, MEM_BYTES - 1));
            endcase
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'b11 && $urandom_range(0, 1) == 1) sz = 2'b10;
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 0, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 512, byte capacity of attached memory; legal addr range 0..MEM_BYTES-4.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  1  processor request strobe, sampled only in IDLE.
REQ-005 we  input  1  1=store, 0=load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 addr  input  32  byte address, little-endian.
REQ-009 wdata  input  32  store data; low 8/16/32 bits used per size.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; request rejected, no memory access made.
REQ-013 rdata  output  32  load result, valid while done=1; 0 on stores and errors.
REQ-014 mem_addr  output  32  byte address to memory.
REQ-015 mem_wdata  output  32  write data to memory.
REQ-016 mem_ren  output  1  memory read enable.
REQ-017 mem_wen  output  1  memory write enable.
REQ-018 mem_rdata  input  32  memory read data, valid in the cycle after mem_ren is sampled.

Function
REQ-019 All outputs SHALL be registered; mem_ren and mem_wen SHALL never be high in the same cycle.
REQ-020 FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
REQ-021 IDLE: on req=1, SHALL latch we/size/sign_ext/addr/wdata; go to DONE with err if illegal, WR_ISSUE for word store, else RD_ISSUE.
REQ-022 Illegal request: size=11 or addr > MEM_BYTES-4 (plus misalignment per REQ-033).
REQ-023 RD_ISSUE: mem_ren=1, mem_addr=latched addr, one cycle; next RD_WAIT.
REQ-024 RD_WAIT: SHALL capture mem_rdata; load -> DONE; sub-word store -> WR_ISSUE.
REQ-025 Load result: byte = mem_rdata[7:0], half = mem_rdata[15:0], extended to 32 bits per sign_ext; word passed unchanged.
REQ-026 Sub-word store SHALL be read-modify-write: mem_wdata = {captured[31:8], wdata[7:0]} for byte, {captured[31:16], wdata[15:0]} for half.
REQ-027 WR_ISSUE: mem_wen=1, mem_addr=latched addr, mem_wdata per REQ-026 or wdata for word; one cycle; next DONE.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; req SHALL NOT be accepted in DONE.
REQ-029 Latency from accepting edge to done high: load 3 cycles, word store 2, sub-word store 4, error 1.
REQ-030 req while busy=1 SHALL be ignored, not queued; inputs may change freely after acceptance.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE and clear busy, done, err, rdata, mem_addr, mem_wdata, mem_ren, mem_wen to 0, overriding any state.
REQ-032 Reset mid-operation SHALL abort; a pending WR_ISSUE SHALL not issue; no done pulse for the aborted request.

Configuration
REQ-033 Macro MEM_ACC_ALIGN_CHK_EN: defined -> halfword with addr[0]!=0 or word with addr[1:0]!=0 is illegal (err, no access); undefined -> misaligned accesses issued normally.

Verification
REQ-034 Word store 0xDEADBEEF @0x10, then word load @0x10 -> rdata=0xDEADBEEF, done 3 cycles after load accepted, err=0.
REQ-035 Memory @0x20=0x11223344; byte store 0xAA @0x20 -> one ren then one wen, mem_wdata=0x112233AA; done 4 cycles after accept.
REQ-036 Memory @0x30 byte 0x80: byte load sign_ext=1 -> rdata=0xFFFFFF80; sign_ext=0 -> 0x00000080.
REQ-037 size=11, or word load @0x1FE (MEM_BYTES=512) -> done+err next cycle, rdata=0, mem_ren/mem_wen never asserted.
REQ-038 Assert reset in RD_WAIT of a byte store -> next cycle all outputs 0, IDLE, no mem_wen, no done.
REQ-039 With MEM_ACC_ALIGN_CHK_EN: halfword load @0x21 -> err; without: same access returns bytes 0x21..0x22, err=0.
